// File: rtl/watch_button_frontend.sv
// watch_button_frontend: 1 Hz watch clock plus debounced mode/set pulses.
// Optional hold-to-repeat on set when WATCH_SET_AUTOREPEAT_EN is defined.
module watch_button_frontend #(
  parameter int unsigned CLK_HZ          = 32768,
  parameter int unsigned DEBOUNCE_CYCLES = 655,
  parameter int unsigned REPEAT_DELAY    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_mode,
  input  logic btn_set,
  output logic watch_clk,
  output logic mode,
  output logic set
);

  localparam int unsigned CW = $clog2(CLK_HZ);
  localparam int unsigned DW =
    (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  if ((CLK_HZ % 2) != 0 || CLK_HZ < 4 ||
      DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1) begin : g_bad_params
    $error("watch_button_frontend: illegal parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    HIGH,
    GAP
  } pstate_e;

  typedef struct packed {
    logic    pend;
    pstate_e st;
  } pfsm_t;

  // One pulse FSM step; permit gates entry into HIGH.
  function automatic pfsm_t step(
    input pfsm_t cur,
    input logic  press,
    input logic  tick,
    input logic  permit
  );
    pfsm_t n;
    n = cur;
    unique case (cur.st)
      IDLE: begin
        n.pend = 1'b0;
        if (press) n.st = ARMED;
      end
      ARMED: begin
        if (press) n.pend = 1'b1;
        if (tick && permit) n.st = HIGH;
      end
      HIGH: begin
        if (press) n.pend = 1'b1;
        if (tick) n.st = GAP;
      end
      GAP: begin
        if (!tick) begin
          if (press) n.pend = 1'b1;
        end else if (cur.pend || press) begin
          n.pend = 1'b0;
          n.st   = permit ? HIGH : ARMED;
        end else begin
          n.st = IDLE;
        end
      end
      default: n = '{pend: 1'b0, st: IDLE};
    endcase
    return n;
  endfunction

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          fall_tick;

  assign fall_tick = (cnt == CW'(CLK_HZ - 1));
  assign cnt_nxt   = fall_tick ? '0 : cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      watch_clk <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      watch_clk <= (cnt_nxt >= CW'(CLK_HZ / 2));
    end
  end

  // Index 0 is mode, index 1 is set.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    stable;
  logic [1:0]    hit;
  logic [1:0]    press;
  logic [DW-1:0] db_cnt [2];

  always_comb begin
    hit   = '0;
    press = '0;
    for (int i = 0; i < 2; i++) begin
      hit[i]   = (sync2[i] != stable[i]) &&
                 (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1));
      press[i] = hit[i] & sync2[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= '0;
      sync2     <= '0;
      stable    <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1 <= {btn_set, btn_mode};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (hit[i]) begin
          db_cnt[i] <= '0;
          stable[i] <= ~stable[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic set_press;

`ifdef WATCH_SET_AUTOREPEAT_EN
  localparam int unsigned HW = $clog2(REPEAT_DELAY + 2);

  logic [HW-1:0] hold_cnt;
  logic          rep_phase;
  logic          at_delay;

  assign at_delay  = (hold_cnt == HW'(REPEAT_DELAY));
  // Inject on every other fall_tick once the hold delay has elapsed.
  assign set_press = press[1] |
                     (fall_tick & stable[1] & at_delay & ~rep_phase);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt  <= '0;
      rep_phase <= 1'b0;
    end else if (!stable[1]) begin
      hold_cnt  <= '0;
      rep_phase <= 1'b0;
    end else if (fall_tick) begin
      if (!at_delay) hold_cnt <= hold_cnt + 1'b1;
      else rep_phase <= ~rep_phase;
    end
  end
`else
  assign set_press = press[1];
`endif

  pfsm_t mode_q;
  pfsm_t mode_d;
  pfsm_t set_q;
  pfsm_t set_d;

  // Mode always wins; set may only enter HIGH when mode will not be HIGH.
  always_comb begin
    mode_d = step(mode_q, press[0], fall_tick, 1'b1);
    set_d  = step(set_q, set_press, fall_tick, mode_d.st != HIGH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= '{pend: 1'b0, st: IDLE};
      set_q  <= '{pend: 1'b0, st: IDLE};
      mode   <= 1'b0;
      set    <= 1'b0;
    end else begin
      mode_q <= mode_d;
      set_q  <= set_d;
      mode   <= (mode_d.st == HIGH);
      set    <= (set_d.st == HIGH);
    end
  end

endmodule
